rotor2_inv: RTL and testbench

ROTOR2_INV -- requirements
Module: rotor2_inv

---
 rtl/rotor2_inv.sv | 121 ++++++++++++
 tb/tb_rotor2_inv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotor2_inv.sv
// Return-path decoder for rotor 2: recovers the input-side letter from a reflector-side code.
// Optional macro ROTOR2_INV_AUTOSTEP_EN advances the rotor on every accepted input.
module rotor2_inv #(
    parameter int unsigned RESET_POS = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_code,
    input  logic       step,
    input  logic       load,
    input  logic [4:0] load_pos,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_code,
    output logic       out_err,
    output logic [4:0] pos,
    output logic       notch_out
);

    localparam int unsigned CW   = 5;
    localparam int unsigned TW   = 6;
    localparam int unsigned NPOS = 26;
    localparam logic [CW-1:0] LAST_POS = CW'(NPOS - 1);

    // Inverse wiring table, indexed by t in 1..26.
    function automatic logic [CW-1:0] minv(input logic [TW-1:0] t);
        case (t)
            6'd1:    minv = 5'd6;
            6'd2:    minv = 5'd13;
            6'd3:    minv = 5'd18;
            6'd4:    minv = 5'd5;
            6'd5:    minv = 5'd16;
            6'd6:    minv = 5'd1;
            6'd7:    minv = 5'd21;
            6'd8:    minv = 5'd17;
            6'd9:    minv = 5'd15;
            6'd10:   minv = 5'd14;
            6'd11:   minv = 5'd3;
            6'd12:   minv = 5'd22;
            6'd13:   minv = 5'd19;
            6'd14:   minv = 5'd8;
            6'd15:   minv = 5'd2;
            6'd16:   minv = 5'd10;
            6'd17:   minv = 5'd9;
            6'd18:   minv = 5'd23;
            6'd19:   minv = 5'd20;
            6'd20:   minv = 5'd25;
            6'd21:   minv = 5'd4;
            6'd22:   minv = 5'd26;
            6'd23:   minv = 5'd12;
            6'd24:   minv = 5'd11;
            6'd25:   minv = 5'd24;
            6'd26:   minv = 5'd7;
            default: minv = 5'd0;
        endcase
    endfunction

    logic          accept;
    logic          adv;
    logic          code_bad;
    logic [TW-1:0] t_sum;
    logic [TW-1:0] t_mod;
    logic [TW-1:0] t_idx;
    logic [CW-1:0] dec_code;
    logic [CW-1:0] load_val;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Undo the rotor offset; a zero remainder maps to letter slot 26.
    always_comb begin
        t_sum    = TW'(in_code) + TW'(NPOS) - TW'(pos);
        t_mod    = (t_sum >= TW'(NPOS)) ? t_sum - TW'(NPOS) : t_sum;
        t_idx    = (t_mod == '0) ? TW'(NPOS) : t_mod;
        code_bad = (in_code > LAST_POS);
        dec_code = code_bad ? '0 : minv(t_idx);
    end

    always_comb begin
        load_val = (load_pos > LAST_POS) ? '0 : load_pos;
`ifdef ROTOR2_INV_AUTOSTEP_EN
        adv = step || accept;
`else
        adv = step;
`endif
    end

    // Result register and rotor position; decode above always sees the pre-edge pos.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_err   <= 1'b0;
            notch_out <= 1'b0;
            pos       <= CW'(RESET_POS);
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_code  <= dec_code;
                out_err   <= code_bad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            notch_out <= 1'b0;
            if (load) begin
                pos <= load_val;
            end else if (adv) begin
                if (pos == LAST_POS) begin
                    pos       <= '0;
                    notch_out <= 1'b1;
                end else begin
                    pos <= pos + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rotor2_inv.sv
// Scoreboard bench for rotor2_inv; expected results come from a table model and a forward encoder.
module tb_rotor2_inv;

    localparam int unsigned RP = 0;
`ifdef ROTOR2_INV_AUTOSTEP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] in_code = '0;
    logic [4:0] load_pos = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_err;
    logic       notch_out;
    logic [4:0] out_code;
    logic [4:0] pos;

    rotor2_inv #(.RESET_POS(RP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .step(step), .load(load), .load_pos(load_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_err(out_err), .pos(pos), .notch_out(notch_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int minv_t[27] = '{0, 6, 13, 18, 5, 16, 1, 21, 17, 15, 14, 3, 22, 19, 8,
                       2, 10, 9, 23, 20, 25, 4, 26, 12, 11, 24, 7};
    int mfwd[27];
    logic [5:0] exp_q[$];
    bit mvalid = 1'b0;
    int mpos = RP;
    bit mnotch = 1'b0;

    function automatic logic [5:0] model_dec(input int y, input int r);
        int t;
        if (y > 25) return {1'b1, 5'd0};
        t = (y + 26 - r) % 26;
        if (t == 0) t = 26;
        return {1'b0, 5'(minv_t[t])};
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic drive_cycle(input bit iv, input int code, input bit st, input bit ld,
                               input int lp, input bit ordy);
        bit acc;
        bit cons;
        logic [5:0] e;
        in_valid = iv; in_code = 5'(code); step = st; load = ld;
        load_pos = 5'(lp); out_ready = ordy;
        acc = iv && (!mvalid || ordy);
        cons = mvalid && ordy;
        e = model_dec(code, mpos);
        @(posedge clk);
        if (cons && exp_q.size() > 0) exp_q.delete(0);
        if (acc) exp_q.push_back(e);
        mvalid = acc || (mvalid && !ordy);
        mnotch = 1'b0;
        if (ld) mpos = (lp > 25) ? 0 : lp;
        else if (st || (AUTO && acc)) begin
            if (mpos == 25) begin mpos = 0; mnotch = 1'b1; end
            else mpos = mpos + 1;
        end
        @(negedge clk);
        in_valid = 1'b0; step = 1'b0; load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        mvalid = 1'b0; mpos = RP; mnotch = 1'b0;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; step = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_code = 5'd5; step = 1'b1; load = 1'b1; load_pos = 5'd7; out_ready = 1'b0;
        do_reset();
        total++;
        if ({out_valid, out_err, out_code, notch_out, pos, in_ready} !== {1'b0, 1'b0, 5'd0, 1'b0, 5'(RP), 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%b e=%b c=%0d n=%b p=%0d r=%b", out_valid, out_err, out_code, notch_out, pos, in_ready);
        end
        drive_cycle(1'b1, 6, 1'b0, 1'b0, 0, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_mid_pre: got v=%b want 1", out_valid); end
        in_valid = 1'b1; in_code = 5'd9; step = 1'b1; load = 1'b1; load_pos = 5'd9; out_ready = 1'b0;
        do_reset();
        total++;
        if ({out_valid, notch_out, pos, in_ready} !== {1'b0, 1'b0, 5'(RP), 1'b1}) begin
            bad++;
            $display("FAIL reset_mid: got v=%b n=%b p=%0d r=%b want v=0 n=0 p=%0d r=1", out_valid, notch_out, pos, in_ready, RP);
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_cycle(1'b1, 6, 1'b0, 1'b0, 0, 1'b1);
        total++;
        if ({out_valid, out_err, out_code} !== {1'b1, 1'b0, 5'd1}) begin
            bad++; $display("FAIL basic_y6: got v=%b e=%b c=%0d want v=1 e=0 c=1", out_valid, out_err, out_code);
        end
        total++;
        if (exp_q.size() == 0 || {out_err, out_code} !== exp_q[0]) begin
            bad++; $display("FAIL basic_sb: got %h want %h", {out_err, out_code}, (exp_q.size() > 0) ? exp_q[0] : 6'h3f);
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got v=%b want 0", out_valid); end
    endtask

    task automatic test_load();
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 3, 1'b1);
        total++;
        if (pos !== 5'd3) begin bad++; $display("FAIL load_pos3: got %0d want 3", pos); end
        drive_cycle(1'b1, 3, 1'b0, 1'b0, 0, 1'b1);
        total++;
        if ({out_valid, out_err, out_code} !== {1'b1, 1'b0, 5'd7}) begin
            bad++; $display("FAIL load_t0: got v=%b e=%b c=%0d want v=1 e=0 c=7", out_valid, out_err, out_code);
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 30, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd0, 1'b0}) begin bad++; $display("FAIL load_clamp: got p=%0d n=%b want p=0 n=0", pos, notch_out); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 25, 1'b1);
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd0, 1'b0}) begin bad++; $display("FAIL load_zero_nonotch: got p=%0d n=%b want p=0 n=0", pos, notch_out); end
    endtask

    task automatic test_notch();
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 24, 1'b1);
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd25, 1'b0}) begin bad++; $display("FAIL notch_pre: got p=%0d n=%b want p=25 n=0", pos, notch_out); end
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd0, 1'b1}) begin bad++; $display("FAIL notch_wrap: got p=%0d n=%b want p=0 n=1", pos, notch_out); end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd0, 1'b0}) begin bad++; $display("FAIL notch_one_cycle: got p=%0d n=%b want p=0 n=0", pos, notch_out); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 25, 1'b1);
        drive_cycle(1'b0, 0, 1'b1, 1'b1, 7, 1'b1);
        total++;
        if ({pos, notch_out} !== {5'd7, 1'b0}) begin bad++; $display("FAIL load_over_step: got p=%0d n=%b want p=7 n=0", pos, notch_out); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 5, 1'b1);
        drive_cycle(1'b1, 5, 1'b1, 1'b0, 0, 1'b1);
        total++;
        if ({out_valid, out_code, pos} !== {1'b1, 5'd7, 5'd6}) begin
            bad++; $display("FAIL decode_old_pos: got v=%b c=%0d p=%0d want v=1 c=7 p=6", out_valid, out_code, pos);
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_err_hold();
        drive_cycle(1'b1, 30, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 6, 1'b0, 1'b0, 0, 1'b0);
            total++;
            if ({out_valid, out_err, out_code, in_ready} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
                bad++; $display("FAIL err_hold[%0d]: got v=%b e=%b c=%0d r=%b want v=1 e=1 c=0 r=0", i, out_valid, out_err, out_code, in_ready);
            end
        end
        drive_cycle(1'b1, 6, 1'b0, 1'b0, 0, 1'b1);
        total++;
        if (!mvalid || exp_q.size() != 1 || {out_valid, out_err, out_code} !== {1'b1, exp_q[0]}) begin
            bad++; $display("FAIL err_release: got v=%b e=%b c=%0d qsize=%0d", out_valid, out_err, out_code, exp_q.size());
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs_s;
        logic [7:0] exp_s;
        for (int i = 0; i < 120; i++) begin
            bit full;
            full = (i < 30);
            drive_cycle(full ? 1'b1 : ($urandom_range(0, 3) != 0), $urandom_range(0, 31),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 31), full ? 1'b1 : ($urandom_range(0, 3) != 0));
            obs_s = {out_valid, pos, notch_out, in_ready};
            exp_s = {mvalid, 5'(mpos), mnotch, (!mvalid || out_ready)};
            total++;
            if (obs_s !== exp_s) begin
                bad++; $display("FAIL b2b_status[%0d]: got %b want %b", i, obs_s, exp_s);
            end
            if (mvalid) begin
                total++;
                if (exp_q.size() == 0 || {out_err, out_code} !== exp_q[0]) begin
                    bad++; $display("FAIL b2b_data[%0d]: got e=%b c=%0d want %h", i, out_err, out_code, (exp_q.size() > 0) ? exp_q[0] : 6'h3f);
                end
            end
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_sweep();
        int y;
        for (int r = 0; r < 26; r++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b1, r, 1'b1);
            for (int x = 1; x <= 26; x++) begin
                y = (mfwd[x] + mpos) % 26;
                drive_cycle(1'b1, y, 1'b0, 1'b0, 0, 1'b1);
                total++;
                if ({out_valid, out_err, out_code, pos} !== {1'b1, 1'b0, 5'(x), 5'(mpos)}) begin
                    bad++; $display("FAIL sweep r=%0d x=%0d: got v=%b e=%b c=%0d p=%0d want c=%0d p=%0d", r, x, out_valid, out_err, out_code, pos, x, mpos);
                end
            end
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        for (int t = 1; t <= 26; t++) mfwd[minv_t[t]] = t;
        test_reset();
        test_basic();
        test_load();
        test_notch();
        test_err_hold();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
